// File: rtl/cache_miss_handler.sv
// Miss handler for a direct-mapped, write-through, write-allocate cache.
// Serves read hits combinationally, refills on read misses and forwards every store to memory.
module cache_miss_handler #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  cache_we,
    output logic [DATA_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    typedef enum logic [1:0] {IDLE, RD_MISS, FILL, WR_THRU} state_t;

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_fillData;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_hitCnt;
    logic [CNT_WIDTH-1:0]  r_missCnt;

    logic w_idle;
    logic w_waiting;
    logic w_timeout;
    logic w_store;
    logic w_hit;
    logic w_miss;

    assign w_idle    = (r_state == IDLE);
    assign w_waiting = (r_state == RD_MISS) || (r_state == WR_THRU);
    assign w_timeout = w_waiting && (r_wait == WAIT_W'(TIMEOUT));
    assign w_store   = w_idle && cpu_we;
    assign w_hit     = w_idle && cpu_re && !cpu_we && cache_hit;
    assign w_miss    = w_idle && cpu_re && !cpu_we && !cache_hit;

    // A timeout takes priority over a late mem_ack arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_fillData <= '0;
            r_wait     <= '0;
            r_err      <= 1'b0;
            r_hitCnt   <= '0;
            r_missCnt  <= '0;
        end else begin
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (cpu_we) begin
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_wait  <= '0;
                        r_state <= WR_THRU;
                    end else if (cpu_re) begin
                        if (cache_hit) begin
                            if (r_hitCnt != '1) r_hitCnt <= r_hitCnt + 1'b1;
                        end else begin
                            r_addr  <= cpu_addr;
                            r_wait  <= '0;
                            r_state <= RD_MISS;
                            if (r_missCnt != '1) r_missCnt <= r_missCnt + 1'b1;
                        end
                    end
                end
                RD_MISS: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                    end else if (mem_ack) begin
                        r_fillData <= mem_rdata;
                        r_state    <= FILL;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                FILL: begin
                    r_state <= IDLE;
                end
                WR_THRU: begin
                    if (w_timeout || mem_ack) begin
                        r_state <= IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall and cache strobe are gated by rst so they drop the moment reset is asserted.
    assign cpu_stall = !rst && (w_store || w_miss ||
                                ((r_state == RD_MISS) && !w_timeout) ||
                                ((r_state == WR_THRU) && !mem_ack && !w_timeout));
    assign cache_we    = !rst && (w_store || (r_state == FILL));
    assign cache_addr  = w_idle ? cpu_addr : r_addr;
    assign cache_wdata = (r_state == FILL) ? r_fillData : cpu_wdata;
    assign cpu_rdata   = w_hit ? cache_rdata :
                         ((r_state == FILL) ? r_fillData : '0);

    assign mem_req   = w_waiting;
    assign mem_we    = (r_state == WR_THRU);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign err      = r_err || w_timeout;
    assign hit_cnt  = r_hitCnt;
    assign miss_cnt = r_missCnt;

endmodule
